regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: the ALU result path (port A) and the load-data path (port B). Round-robin arbitration, a registered one-hot write-enable stage that drives the register file's 32 per-register enables directly, and a 32-entry pending-write scoreboard that the issue logic uses for read-after-write hazard checks. Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Purpose : round-robin share of the register file write port between ALU (A) and load (B) writeback.
// Latency : 1 cycle from accepted transfer to wr_valid/wr_en/wr_addr/wr_data; pending updates 1 cycle after cause.
// Backpres: a_ready/b_ready are combinational grants from valids + priority; the loser waits with its request held.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   a_valid/a_ready/...   - ALU writeback request (addr, data)
//   b_valid/b_ready/...   - load writeback request (addr, data)
//   iss_valid, iss_addr   - destination register of an issuing instruction (marks it pending)
//   wr_valid, wr_en,      - registered write to the register file; wr_en is one-hot and
//   wr_addr, wr_data        is never set for register 0
//   pending               - per-register outstanding-write scoreboard for RAW hazard checks
module regfile_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_addr,
  output logic              wr_valid,
  output logic [31:0]       wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       pending
);

  typedef enum logic {PRI_A, PRI_B} pri_t;

  pri_t              state, state_nxt;
  logic              xfer;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       sel_onehot;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;

  always_ff @(posedge clk) begin
    if (rst) state <= PRI_A;
    else     state <= state_nxt;
  end

  // Grant and next priority. Readies are forced low during reset so no
  // requester sees a transfer that the reset would then discard.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    state_nxt = state;
    if (!rst) begin
      if (a_valid && (!b_valid || state == PRI_A)) a_ready = 1'b1;
      else if (b_valid)                           b_ready = 1'b1;
    end
    if (a_ready)      state_nxt = PRI_B;
    else if (b_ready) state_nxt = PRI_A;
  end

  assign xfer = a_ready | b_ready;

  always_comb begin
    sel_addr   = b_ready ? b_addr : a_addr;
    sel_data   = b_ready ? b_data : a_data;
    sel_onehot = 32'd0;
    if (xfer && sel_addr != 5'd0) sel_onehot[sel_addr] = 1'b1;
  end

  // Scoreboard update vectors. Register 0 never appears in either, which
  // keeps pending[0] at zero. Set is OR'd in after the clear so a newer
  // issue to the register being written keeps it pending.
  always_comb begin
    set_vec = 32'd0;
    if (iss_valid && iss_addr != 5'd0) set_vec[iss_addr] = 1'b1;
    clr_vec = sel_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_en    <= 32'd0;
      wr_addr  <= 5'd0;
      wr_data  <= '0;
      pending  <= 32'd0;
    end else begin
      wr_valid <= xfer;
      wr_en    <= sel_onehot;
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, contention, single requester,
// register 0, scoreboard set/clear and mid-operation reset.
// Inputs change 1 time unit after a rising edge; outputs sampled at edge+1/+2.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, iss_addr;
  logic [31:0] a_data, b_data;
  logic        wr_valid;
  logic [31:0] wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wr_valid(wr_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected grant pattern for four cycles of contention: A,B,A,B
  logic [3:0] exp_a_grant;
  logic [31:0] exp_en;

  initial begin
    exp_a_grant = 4'b0101;
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22;
    iss_valid = 1'b0; iss_addr = 5'd0;

    // Reset held two cycles with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
      check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
      check("rst_wr_en", wr_en, 32'd0);
      check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_pending", pending, 32'd0);
    end
    rst = 1'b0;
    #1;

    // Contention: A,B,A,B; write appears the cycle after each grant
    for (int i = 0; i < 4; i++) begin
      check("cont_a_ready", {31'd0, a_ready}, {31'd0, exp_a_grant[i]});
      check("cont_b_ready", {31'd0, b_ready}, {31'd0, ~exp_a_grant[i]});
      tick();
      exp_en = exp_a_grant[i] ? 32'h00000008 : 32'h00000020;
      check("cont_wr_valid", {31'd0, wr_valid}, 32'd1);
      check("cont_wr_en", wr_en, exp_en);
      check("cont_wr_data", wr_data, exp_a_grant[i] ? 32'h11 : 32'h22);
    end

    // Single requester B to register 31, three cycles back to back
    a_valid = 1'b0;
    b_addr  = 5'd31;
    for (int i = 0; i < 3; i++) begin
      b_data = 32'h100 + 32'(i);
      #1;
      check("solo_b_ready", {31'd0, b_ready}, 32'd1);
      check("solo_a_ready", {31'd0, a_ready}, 32'd0);
      tick();
      check("solo_wr_en", wr_en, 32'h80000000);
      check("solo_wr_data", wr_data, 32'h100 + 32'(i));
    end
    // last grant was B, so A must now win contention
    a_valid = 1'b1;
    #1;
    check("pri_a_after_b", {31'd0, a_ready}, 32'd1);
    check("pri_b_blocked", {31'd0, b_ready}, 32'd0);
    // both withdraw before the edge: no write, addr/data hold
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("idle_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("idle_wr_en", wr_en, 32'd0);
    check("idle_wr_addr", {27'd0, wr_addr}, 32'd31);
    check("idle_wr_data", wr_data, 32'h102);

    // Register 0: write emitted with no enable; issue to r0 ignored
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    check("r0_a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    check("r0_wr_valid", {31'd0, wr_valid}, 32'd1);
    check("r0_wr_en", wr_en, 32'd0);
    check("r0_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("r0_wr_data", wr_data, 32'hDEAD);
    check("r0_pending", pending, 32'd0);

    // Scoreboard
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    check("sb_set7", pending, 32'h00000080);
    // write 7 while 7 issues again: set wins
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    tick();
    check("sb_set_wins_en", wr_en, 32'h00000080);
    check("sb_set_wins", pending, 32'h00000080);
    // write 7 while 9 issues: both take effect
    a_data = 32'h78; iss_addr = 5'd9;
    tick();
    check("sb_diff_regs", pending, 32'h00000200);
    // write 9 with no issue: clears to zero
    iss_valid = 1'b0; a_addr = 5'd9; a_data = 32'h99;
    tick();
    check("sb_clear9_en", wr_en, 32'h00000200);
    check("sb_clear9", pending, 32'd0);

    // Mid-operation reset: B write first so A holds priority, mark r12 pending
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    iss_valid = 1'b1; iss_addr = 5'd12;
    tick();
    check("mr_pre_en", wr_en, 32'h00000010);
    check("mr_pre_pending", pending, 32'h00001000);
    iss_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'hA2;
    b_addr = 5'd6; b_data = 32'hB6;
    #1;
    check("mr_b_waiting", {31'd0, b_ready}, 32'd0);
    check("mr_a_granted", {31'd0, a_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("mr_rst_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    check("mr_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("mr_wr_en", wr_en, 32'd0);
    check("mr_pending", pending, 32'd0);
    tick();
    check("mr_wr_valid2", {31'd0, wr_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("mr_post_a_ready", {31'd0, a_ready}, 32'd1);
    check("mr_post_b_ready", {31'd0, b_ready}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("mr_post_idle", {31'd0, wr_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
